// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- inter-stage pipeline register with valid/ready flow control.
//
// Payload is split into CTRL (write enables, result select), which is zeroed
// whenever the entry holding it becomes a bubble, and DATA, which is held
// rather than cleared.
//
// Parameters
//   CTRL_W  control bits per entry
//   DATA_W  data bits per entry
//   SKID    1 = two-entry skid buffer with registered in_ready
//           0 = single register with combinational in_ready
//   CNT_W   width of the saturating stall-cycle counter
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   flush      drop every held entry and the incoming beat this cycle
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat
//   in_ctrl    upstream control
//   in_data    upstream data
//   out_valid  downstream beat valid
//   out_ready  downstream accepts the beat
//   out_ctrl   head control, forced to 0 when out_valid=0
//   out_data   head data (don't-care when out_valid=0)
//   stall_cnt  count of edges with out_valid=1 and out_ready=0
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DATA_W = 133,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_ready_q;
    logic              head_valid;
    logic              in_xfer;
    logic              out_xfer;

    assign head_valid = (state != EMPTY);

    // With the skid buffer, in_ready comes straight from a flop so that there
    // is no combinational path from out_ready back to the upstream stage.
    always_comb begin
        if (SKID != 0) begin
            in_ready = in_ready_q;
        end else begin
            in_ready = !head_valid || out_ready;
        end
    end

    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = head_valid && out_ready;

    assign out_valid = head_valid;
    assign out_ctrl  = head_valid ? head_ctrl : '0;
    assign out_data  = head_data;

    // Single-register mode only ever uses EMPTY and ONE. Flush clears valids
    // and control but deliberately leaves the data registers untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            head_ctrl  <= '0;
            head_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= EMPTY;
            head_ctrl  <= '0;
            skid_ctrl  <= '0;
            in_ready_q <= 1'b1;
        end else if (SKID == 0) begin
            if (in_xfer) begin
                state     <= ONE;
                head_ctrl <= in_ctrl;
                head_data <= in_data;
            end else if (out_xfer) begin
                state     <= EMPTY;
                head_ctrl <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state     <= ONE;
                        head_ctrl <= in_ctrl;
                        head_data <= in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_ctrl <= in_ctrl;
                        head_data <= in_data;
                    end else if (in_xfer) begin
                        state      <= FULL;
                        skid_ctrl  <= in_ctrl;
                        skid_data  <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state     <= EMPTY;
                        head_ctrl <= '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the head can move.
                    if (out_xfer) begin
                        state      <= ONE;
                        head_ctrl  <= skid_ctrl;
                        head_data  <= skid_data;
                        skid_ctrl  <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    head_ctrl  <= '0;
                    skid_ctrl  <= '0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Saturating stall counter; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (head_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: a directed vector table for the skid-buffer
// variant, randomized traffic on both variants against a bounded-FIFO
// reference model, mid-stream async reset, and counter saturation.
module tb_pipe_stage_reg;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [3:0]   in_ctrl;
    logic [132:0] in_data;
    logic         out_ready;

    logic         a_ir, a_ov;
    logic [3:0]   a_oc;
    logic [132:0] a_od;
    logic [15:0]  a_sc;

    logic         b_ir, b_ov;
    logic [3:0]   b_oc;
    logic [132:0] b_od;
    logic [15:0]  b_sc;

    logic         c_iv, c_or;
    logic [7:0]   c_id;
    logic         c_ir, c_ov;
    logic [3:0]   c_oc;
    logic [7:0]   c_od;
    logic [1:0]   c_sc;

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(133), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_ir), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_ov), .out_ready(out_ready), .out_ctrl(a_oc), .out_data(a_od),
        .stall_cnt(a_sc)
    );

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(133), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_ir), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(b_ov), .out_ready(out_ready), .out_ctrl(b_oc), .out_data(b_od),
        .stall_cnt(b_sc)
    );

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(8), .SKID(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(c_iv), .in_ready(c_ir), .in_ctrl(4'h3), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_ctrl(c_oc), .out_data(c_od),
        .stall_cnt(c_sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Reference model: the stage is a bounded FIFO in arrival order
    // (capacity 2 with skid, 1 without).
    typedef struct {
        logic [3:0]   c;
        logic [132:0] d;
    } beat_t;

    beat_t       qa[$];
    beat_t       qb[$];
    int unsigned sa, sb;

    task automatic check_models();
        chk("a_out_valid", 133'(a_ov), 133'(qa.size() > 0));
        chk("a_in_ready", 133'(a_ir), 133'(qa.size() < 2));
        chk("a_out_ctrl", 133'(a_oc), (qa.size() > 0) ? 133'(qa[0].c) : '0);
        if (qa.size() > 0) chk("a_out_data", a_od, qa[0].d);
        chk("a_stall_cnt", 133'(a_sc), 133'(sa));
        chk("b_out_valid", 133'(b_ov), 133'(qb.size() > 0));
        chk("b_in_ready", 133'(b_ir), 133'((qb.size() == 0) || out_ready));
        chk("b_out_ctrl", 133'(b_oc), (qb.size() > 0) ? 133'(qb[0].c) : '0);
        if (qb.size() > 0) chk("b_out_data", b_od, qb[0].d);
        chk("b_stall_cnt", 133'(b_sc), 133'(sb));
    endtask

    task automatic update_models();
        beat_t nb;
        bit    rdy_a, rdy_b;
        nb.c  = in_ctrl;
        nb.d  = in_data;
        rdy_a = (qa.size() < 2);
        rdy_b = (qb.size() == 0) || out_ready;
        if (qa.size() > 0 && !out_ready && sa < 65535) sa++;
        if (qb.size() > 0 && !out_ready && sb < 65535) sb++;
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0 && out_ready) void'(qa.pop_front());
            if (in_valid && rdy_a) qa.push_back(nb);
            if (qb.size() > 0 && out_ready) void'(qb.pop_front());
            if (in_valid && rdy_b) qb.push_back(nb);
        end
    endtask

    // One clock: inputs already applied at posedge+1, compare at negedge.
    task automatic model_cycle();
        @(negedge clk);
        check_models();
        update_models();
        @(posedge clk);
        #1;
    endtask

    int unsigned seq = 0;

    task automatic rand_beat();
        seq++;
        in_ctrl          = 4'($urandom);
        in_data          = '0;
        in_data[31:0]    = seq;
        in_data[63:32]   = $urandom;
        in_data[95:64]   = $urandom;
        in_data[127:96]  = $urandom;
        in_data[132:128] = 5'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        qa.delete(); qb.delete();
        sa = 0; sb = 0;
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [3:0]  ic;
        logic [31:0] id;
        logic        ordy;
        logic        eov;
        logic [3:0]  ectl;
        logic [31:0] edat;
        logic        eir;
        logic [15:0] estall;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fl, input logic iv, input logic [3:0] ic, input logic [31:0] id,
                       input logic ordy, input logic eov, input logic [3:0] ectl,
                       input logic [31:0] edat, input logic eir, input logic [15:0] estall);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
        v.eov = eov; v.ectl = ectl; v.edat = edat; v.eir = eir; v.estall = estall;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        c_iv = 1'b0; c_or = 1'b0; c_id = '0;
        sa = 0; sb = 0;

        // Streaming, back-pressure, flush of a full stage, bubble control.
        add(1'b0, 1'b1, 4'h1, 32'h1,  1'b1, 1'b0, 4'h0, 32'h0,  1'b1, 16'd0);
        add(1'b0, 1'b1, 4'h2, 32'h2,  1'b1, 1'b1, 4'h1, 32'h1,  1'b1, 16'd0);
        add(1'b0, 1'b1, 4'h3, 32'h3,  1'b1, 1'b1, 4'h2, 32'h2,  1'b1, 16'd0);
        add(1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b1, 4'h3, 32'h3,  1'b1, 16'd0);
        add(1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h0,  1'b1, 16'd0);
        add(1'b0, 1'b1, 4'h5, 32'hA,  1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 16'd0);
        add(1'b0, 1'b1, 4'h6, 32'hB,  1'b0, 1'b1, 4'h5, 32'hA,  1'b1, 16'd0);
        add(1'b0, 1'b1, 4'h7, 32'hC,  1'b0, 1'b1, 4'h5, 32'hA,  1'b0, 16'd1);
        add(1'b0, 1'b1, 4'h7, 32'hC,  1'b0, 1'b1, 4'h5, 32'hA,  1'b0, 16'd2);
        add(1'b0, 1'b1, 4'h7, 32'hC,  1'b1, 1'b1, 4'h5, 32'hA,  1'b0, 16'd3);
        add(1'b0, 1'b1, 4'h7, 32'hC,  1'b1, 1'b1, 4'h6, 32'hB,  1'b1, 16'd3);
        add(1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b1, 4'h7, 32'hC,  1'b1, 16'd3);
        add(1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h0,  1'b1, 16'd3);
        add(1'b0, 1'b1, 4'h8, 32'hE,  1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 16'd3);
        add(1'b0, 1'b1, 4'h9, 32'hF,  1'b0, 1'b1, 4'h8, 32'hE,  1'b1, 16'd3);
        add(1'b1, 1'b1, 4'hD, 32'hD,  1'b0, 1'b1, 4'h8, 32'hE,  1'b0, 16'd4);
        add(1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h0,  1'b1, 16'd5);
        add(1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h0,  1'b1, 16'd5);
        add(1'b0, 1'b1, 4'hF, 32'h55, 1'b1, 1'b0, 4'h0, 32'h0,  1'b1, 16'd5);
        add(1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b1, 4'hF, 32'h55, 1'b1, 16'd5);
        add(1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h0,  1'b1, 16'd5);

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 133'(a_ov), '0);
        chk("rst_out_ctrl", 133'(a_oc), '0);
        chk("rst_out_data", a_od, '0);
        chk("rst_stall_cnt", 133'(a_sc), '0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 133'(a_ir), 133'(1));

        // Directed vector table on the skid variant.
        foreach (tbl[i]) begin
            flush     = tbl[i].fl;
            in_valid  = tbl[i].iv;
            in_ctrl   = tbl[i].ic;
            in_data   = 133'(tbl[i].id);
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 133'(a_ov), 133'(tbl[i].eov));
            chk($sformatf("vec%0d_out_ctrl", i), 133'(a_oc), 133'(tbl[i].ectl));
            if (tbl[i].eov) chk($sformatf("vec%0d_out_data", i), a_od, 133'(tbl[i].edat));
            chk($sformatf("vec%0d_in_ready", i), 133'(a_ir), 133'(tbl[i].eir));
            chk($sformatf("vec%0d_stall_cnt", i), 133'(a_sc), 133'(tbl[i].estall));
            @(posedge clk);
            #1;
        end

        // Continuous input with out_ready toggling every cycle.
        do_reset();
        for (int i = 0; i < 210; i++) begin
            flush     = 1'b0;
            in_valid  = 1'b1;
            out_ready = i[0];
            rand_beat();
            model_cycle();
        end

        // Fully random traffic including occasional flushes.
        for (int i = 0; i < 400; i++) begin
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_beat();
            model_cycle();
        end

        // Fill and stall, then reset asynchronously between edges.
        for (int i = 0; i < 3; i++) begin
            flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
            rand_beat();
            model_cycle();
        end
        #2 reset = 1'b0;
        #1;
        chk("midrst_out_valid", 133'(a_ov), '0);
        chk("midrst_out_ctrl", 133'(a_oc), '0);
        chk("midrst_stall_cnt", 133'(a_sc), '0);
        chk("midrst_b_out_valid", 133'(b_ov), '0);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        qa.delete(); qb.delete();
        sa = 0; sb = 0;
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_ctrl = 4'h3; in_data = 133'(32'h77);
        model_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", 133'(a_ov), 133'(1));
        chk("postrst_out_data", a_od, 133'(32'h77));
        chk("postrst_out_ctrl", 133'(a_oc), 133'(4'h3));
        @(posedge clk);
        #1;

        // Narrow counter saturates at all-ones.
        c_iv = 1'b1; c_or = 1'b0; c_id = 8'h5A;
        @(posedge clk);
        #1;
        c_iv = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            chk($sformatf("sat_stall_cnt_%0d", j), 133'(c_sc), 133'((j - 1 > 3) ? 3 : j - 1));
            chk($sformatf("sat_out_data_%0d", j), 133'(c_od), 133'(8'h5A));
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
